// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types and scoreboard sizing constants.
// Both the register scoreboard and its bench import these definitions.
package riscv_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam int NUM_REGS    = 32;
  localparam int SB_CNT_W    = 3;

  typedef logic [SB_CNT_W-1:0] sb_count_t;

  localparam sb_count_t SB_MAX_OUTSTANDING = sb_count_t'(4);

  // Single-bit mask selecting register r, used for busy-bit set and clear.
  function automatic logic [NUM_REGS-1:0] regMask(input reg_addr_t r);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks long-latency destination registers and stalls
// issue on RAW/WAW hazards or when the outstanding-write table is full.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  reg_addr_t   issue_rs1,
  input  reg_addr_t   issue_rs2,
  input  reg_addr_t   issue_rd,
  input  logic        issue_reg_write,
  input  logic        issue_long,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  reg_addr_t   wb_rd,
  output logic [31:0] busy_vec,
  output logic [2:0]  outstanding,
  output logic        wb_err
);

  logic [NUM_REGS-1:0] r_busyVec;
  sb_count_t           r_outstanding;
  logic                r_wbErr;

  logic                w_retire;
  logic [NUM_REGS-1:0] w_clrMask;
  logic [NUM_REGS-1:0] w_setMask;
  logic [NUM_REGS-1:0] w_effBusy;
  logic                w_raw;
  logic                w_waw;
  logic                w_full;
  logic                w_ready;
  logic                w_set;
  logic [NUM_REGS-1:0] w_busyNext;
  sb_count_t           w_outNext;
  logic                w_errNext;

  // A retiring writeback hides its register from the hazard check because
  // the forwarding path delivers the value in the same cycle.
  always_comb begin
    w_retire   = wb_valid && (wb_rd != '0) && r_busyVec[wb_rd];
    w_clrMask  = w_retire ? regMask(wb_rd) : '0;
    w_effBusy  = r_busyVec & ~w_clrMask;
    w_raw      = ((issue_rs1 != '0) && w_effBusy[issue_rs1]) ||
                 ((issue_rs2 != '0) && w_effBusy[issue_rs2]);
    w_waw      = issue_reg_write && (issue_rd != '0) && w_effBusy[issue_rd];
    w_full     = issue_long && (r_outstanding == SB_MAX_OUTSTANDING) && !w_retire;
    w_ready    = !issue_valid || !(w_raw || w_waw || w_full);
    w_set      = issue_valid && w_ready && issue_long && issue_reg_write &&
                 (issue_rd != '0);
    w_setMask  = w_set ? regMask(issue_rd) : '0;
    w_busyNext = ((r_busyVec & ~w_clrMask) | w_setMask) & ~regMask('0);
    w_outNext  = r_outstanding;
    if (w_set && !w_retire) begin
      w_outNext = r_outstanding + sb_count_t'(1);
    end else if (!w_set && w_retire) begin
      w_outNext = r_outstanding - sb_count_t'(1);
    end
    w_errNext  = r_wbErr || (wb_valid && !w_retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busyVec     <= '0;
      r_outstanding <= '0;
      r_wbErr       <= 1'b0;
    end else begin
      r_busyVec     <= w_busyNext;
      r_outstanding <= w_outNext;
      r_wbErr       <= w_errNext;
    end
  end

  assign issue_ready = w_ready;
  assign busy_vec    = r_busyVec;
  assign outstanding = r_outstanding;
  assign wb_err      = r_wbErr;

endmodule
